fifo_drain: RTL and testbench



---
 rtl/fifo_drain_pkg.sv | 24 ++
 rtl/word_serializer.sv | 50 +++++
 rtl/fifo_drain.sv | 174 +++++++++++++++++
 tb/tb_fifo_drain.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
//   Shared types and constants for the fifo_drain read-side burst engine.
//   - state_t      : FSM state encoding (IDLE, WAIT, LOAD, SHIFT, HDR)
//   - HDR_MAGIC    : tag placed in the top byte of a burst header beat
//   - slice_count(): number of output beats per FIFO word
//   HDR is only reachable when FIFO_DRAIN_HDR_EN is defined.
package fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    SHIFT,
    HDR
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  function automatic int unsigned slice_count(input int unsigned fifo_w,
                                              input int unsigned out_w);
    return fifo_w / out_w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// word_serializer
//   Loads one FIFO word in parallel and presents it as OWIDTH-bit slices,
//   most-significant slice first. The slice only moves on 'advance'
//   (the downstream handshake), so dout is stable while stalled.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture din, restart at the MSB slice
//   din         : DWIDTH-bit word to serialise
//   advance     : accepted beat, move to the next slice
//   dout        : current slice
//   last_slice  : current slice is the least-significant one
module word_serializer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned OWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DWIDTH-1:0] din,
  input  logic              advance,
  output logic [OWIDTH-1:0] dout,
  output logic              last_slice
);

  localparam int unsigned NSLICE = slice_count(DWIDTH, OWIDTH);
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  logic [DWIDTH-1:0] r_shift;
  logic [IW-1:0]     r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (load) begin
      r_shift <= din;
      r_idx   <= '0;
    end else if (advance && !last_slice) begin
      // Shift left so the next slice is always at the top.
      r_shift <= r_shift << OWIDTH;
      r_idx   <= r_idx + 1'b1;
    end
  end

  assign dout       = r_shift[DWIDTH-1 -: OWIDTH];
  assign last_slice = (r_idx == IW'(NSLICE - 1));

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain
//   Read-side companion to sync_fifo. Pops buffered event words in bursts
//   and serialises each into OUT_DWIDTH beats on a valid/ready stream.
//   A burst starts as soon as BURST_LEN words are queued, or after
//   TIMEOUT_CYC cycles of a non-empty FIFO holding fewer words.
//   Optional: define FIFO_DRAIN_HDR_EN to precede every burst with a header
//   beat {HDR_MAGIC, zero pad, burst word count}.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_numel  : FIFO occupancy
//   fifo_rdata  : FIFO head word (show-ahead)
//   fifo_rd_en  : pop strobe, asserted only in LOAD and never when empty
//   out_valid   : beat valid
//   out_ready   : downstream accept
//   out_data    : beat payload
//   out_last    : final beat of the burst
//   busy        : FSM not in IDLE
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned FIFO_DWIDTH = 64,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned OUT_DWIDTH  = 16,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_numel,
  input  logic [FIFO_DWIDTH-1:0]      fifo_rdata,
  output logic                        fifo_rd_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_DWIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC);

`ifdef FIFO_DRAIN_HDR_EN
  localparam state_t BURST_START = HDR;
`else
  localparam state_t BURST_START = LOAD;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tcnt;
  logic [TW-1:0]   w_tcnt_nxt;
  logic [CNTW-1:0] r_burst_cnt;
  logic [CNTW-1:0] w_burst_nxt;

  logic                  w_load;
  logic                  w_adv;
  logic [OUT_DWIDTH-1:0] w_slice;
  logic                  w_last_slice;

`ifdef FIFO_DRAIN_HDR_EN
  logic [OUT_DWIDTH-1:0] w_hdr;

  always_comb begin
    w_hdr = '0;
    w_hdr[OUT_DWIDTH-1 -: 8] = HDR_MAGIC;
    w_hdr[CNTW-1:0]          = r_burst_cnt;
  end
`endif

  word_serializer #(
    .DWIDTH (FIFO_DWIDTH),
    .OWIDTH (OUT_DWIDTH)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .din        (fifo_rdata),
    .advance    (w_adv),
    .dout       (w_slice),
    .last_slice (w_last_slice)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = '0;
    w_burst_nxt = r_burst_cnt;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    fifo_rd_en  = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    busy        = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (fifo_numel >= CNTW'(BURST_LEN)) begin
          w_burst_nxt = CNTW'(BURST_LEN);
          w_state_nxt = BURST_START;
        end else if (!fifo_empty) begin
          w_state_nxt = WAIT;
        end
      end

      WAIT: begin
        // Empty is checked first so a flushed FIFO never latches a
        // zero-length burst on the timeout cycle.
        if (fifo_empty) begin
          w_state_nxt = IDLE;
        end else if (fifo_numel >= CNTW'(BURST_LEN)) begin
          w_burst_nxt = CNTW'(BURST_LEN);
          w_state_nxt = BURST_START;
        end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          w_burst_nxt = fifo_numel;
          w_state_nxt = BURST_START;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      LOAD: begin
        if (fifo_empty) begin
          w_burst_nxt = '0;
          w_state_nxt = IDLE;
        end else begin
          fifo_rd_en  = 1'b1;
          w_load      = 1'b1;
          w_burst_nxt = r_burst_cnt - 1'b1;
          w_state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        out_valid = 1'b1;
        out_data  = w_slice;
        // burst_cnt already counts down in LOAD, so zero means last word.
        out_last  = w_last_slice && (r_burst_cnt == '0);
        w_adv     = out_ready;
        if (out_ready && w_last_slice) begin
          w_state_nxt = (r_burst_cnt != '0) ? LOAD : IDLE;
        end
      end

`ifdef FIFO_DRAIN_HDR_EN
      HDR: begin
        out_valid = 1'b1;
        out_data  = w_hdr;
        if (out_ready) begin
          w_state_nxt = LOAD;
        end
      end
`endif

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain
//   Directed bench for fifo_drain with a pointer-based FIFO model on the
//   read side. Header-beat scenario is built when FIFO_DRAIN_HDR_EN is defined.
module tb_fifo_drain;

  localparam int unsigned FIFO_DWIDTH = 64;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned OUT_DWIDTH  = 16;
  localparam int unsigned BURST_LEN   = 4;
  localparam int unsigned TIMEOUT_CYC = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [4:0]  fifo_numel;
  logic [63:0] fifo_rdata;
  logic        fifo_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  fifo_drain #(
    .FIFO_DWIDTH (FIFO_DWIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .OUT_DWIDTH  (OUT_DWIDTH),
    .BURST_LEN   (BURST_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_numel (fifo_numel),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  // FIFO model: writes from the stimulus process, pops on the DUT strobe.
  logic [63:0] mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        flush = 1'b0;

  assign fifo_empty = (wp == rp);
  assign fifo_numel = 5'(wp - rp);
  assign fifo_rdata = mem[rp % 64];

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_rd_en && (wp != rp)) rp <= rp + 1;
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [15:0] beat_q [$];
  logic        last_q [$];
  int          pop_cyc [$];

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      beat_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (fifo_rd_en) begin
      pop_cyc.push_back(cyc);
      if (fifo_empty) begin
        n_fail++;
        $display("FAIL rd_en_while_empty cycle %0d: got rd_en=1, want 0", cyc);
      end
    end
    cyc++;
  end

  task automatic push(input logic [63:0] w);
    mem[wp % 64] = w;
    wp = wp + 1;
  endtask

  task automatic clear_capture();
    beat_q.delete();
    last_q.delete();
    pop_cyc.delete();
  endtask

  task automatic do_flush();
    @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst   = 1'b0;
    clear_capture();
  endtask

  task automatic test_reset();
    logic [63:0] words [5];
    logic [63:0] w;
    logic [15:0] exp_d;
    int          budget;
    words = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
              64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001,
              64'h0102_0304_0506_0708};
    rst = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    clear_capture();
    for (int i = 0; i < 5; i++) push(words[i]);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({fifo_rd_en, out_valid, out_last, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctrl: got rd/vld/last/busy=%b, want 0000",
                 {fifo_rd_en, out_valid, out_last, busy});
      end
      n_cmp++;
      if (out_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_data: got %h, want 0000", out_data);
      end
    end
    n_cmp++;
    if (pop_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_no_pop: got %0d pops, want 0", pop_cyc.size());
    end
    rst = 1'b0;
    budget = 0;
    while (beat_q.size() < 16 && budget < 80) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (beat_q.size() !== 16) begin
      n_fail++;
      $display("FAIL reset_burst_beats: got %0d, want 16", beat_q.size());
    end
    for (int k = 0; k < 16 && k < beat_q.size(); k++) begin
      w = words[k / 4];
      exp_d = w[63 - 16 * (k % 4) -: 16];
      n_cmp++;
      if (beat_q[k] !== exp_d || last_q[k] !== (k == 15)) begin
        n_fail++;
        $display("FAIL reset_burst_beat%0d: got %h/%b, want %h/%b",
                 k, beat_q[k], last_q[k], exp_d, (k == 15));
      end
    end
    n_cmp++;
    if (pop_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL reset_burst_pops: got %0d, want 4", pop_cyc.size());
    end
    do_flush();
  endtask

  task automatic test_full_burst();
    logic [15:0] exp_slices [4];
    int          budget;
    exp_slices = '{16'h0011, 16'h2233, 16'h4455, 16'h6677};
    @(negedge clk);
    out_ready = 1'b1;
    clear_capture();
    for (int i = 0; i < 4; i++) push(64'h0011_2233_4455_6677);
    budget = 0;
    while (beat_q.size() < 16 && budget < 80) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (beat_q.size() !== 16) begin
      n_fail++;
      $display("FAIL full_beats: got %0d, want 16", beat_q.size());
    end
    for (int k = 0; k < 16 && k < beat_q.size(); k++) begin
      n_cmp++;
      if (beat_q[k] !== exp_slices[k % 4] || last_q[k] !== (k == 15)) begin
        n_fail++;
        $display("FAIL full_beat%0d: got %h/%b, want %h/%b",
                 k, beat_q[k], last_q[k], exp_slices[k % 4], (k == 15));
      end
    end
    n_cmp++;
    if (pop_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL full_pops: got %0d, want 4", pop_cyc.size());
    end
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++) begin
      n_cmp++;
      if (pop_cyc[i] - pop_cyc[i-1] !== 5) begin
        n_fail++;
        $display("FAIL full_pop_spacing%0d: got %0d, want 5", i,
                 pop_cyc[i] - pop_cyc[i-1]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || fifo_numel !== 5'd0) begin
      n_fail++;
      $display("FAIL full_idle_after: got busy=%b numel=%0d, want 0/0",
               busy, fifo_numel);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] words [2];
    logic [63:0] w;
    logic [15:0] exp_d;
    int          c0;
    int          budget;
    words = '{64'hCAFE_0001_BEEF_0002, 64'h1234_5678_9ABC_DEF0};
    @(negedge clk);
    out_ready = 1'b1;
    clear_capture();
    c0 = cyc;
    push(words[0]);
    push(words[1]);
    budget = 0;
    while (beat_q.size() < 8 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (budget == 100) begin
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || pop_cyc.size() !== 0) begin
          n_fail++;
          $display("FAIL timeout_waiting: got busy=%b vld=%b pops=%0d, want 1/0/0",
                   busy, out_valid, pop_cyc.size());
        end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pop_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL timeout_pops: got %0d, want 2", pop_cyc.size());
    end
    if (pop_cyc.size() > 0) begin
      n_cmp++;
      if (pop_cyc[0] !== c0 + 1 + int'(TIMEOUT_CYC)) begin
        n_fail++;
        $display("FAIL timeout_first_pop: got cycle %0d, want %0d",
                 pop_cyc[0], c0 + 1 + int'(TIMEOUT_CYC));
      end
    end
    n_cmp++;
    if (beat_q.size() !== 8) begin
      n_fail++;
      $display("FAIL timeout_beats: got %0d, want 8", beat_q.size());
    end
    for (int k = 0; k < 8 && k < beat_q.size(); k++) begin
      w = words[k / 4];
      exp_d = w[63 - 16 * (k % 4) -: 16];
      n_cmp++;
      if (beat_q[k] !== exp_d || last_q[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL timeout_beat%0d: got %h/%b, want %h/%b",
                 k, beat_q[k], last_q[k], exp_d, (k == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] words [4];
    logic [63:0] w;
    logic [15:0] exp_d;
    logic [15:0] pd;
    logic        pv, pr, pl, have_prev;
    int          phase, budget;
    words = '{64'hA1A2_A3A4_A5A6_A7A8, 64'hB1B2_B3B4_B5B6_B7B8,
              64'hC1C2_C3C4_C5C6_C7C8, 64'hD1D2_D3D4_D5D6_D7D8};
    @(negedge clk);
    out_ready = 1'b0;
    clear_capture();
    for (int i = 0; i < 4; i++) push(words[i]);
    have_prev = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    phase = 0;
    budget = 0;
    while (beat_q.size() < 16 && budget < 300) begin
      @(negedge clk);
      if (have_prev && pv && !pr) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          n_fail++;
          $display("FAIL bp_stall_hold: got %b/%h/%b, want 1/%h/%b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      pv = out_valid;
      pd = out_data;
      pl = out_last;
      pr = (phase % 3 == 0);
      out_ready = pr;
      phase++;
      have_prev = 1'b1;
      budget++;
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (beat_q.size() !== 16) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d, want 16", beat_q.size());
    end
    for (int k = 0; k < 16 && k < beat_q.size(); k++) begin
      w = words[k / 4];
      exp_d = w[63 - 16 * (k % 4) -: 16];
      n_cmp++;
      if (beat_q[k] !== exp_d || last_q[k] !== (k == 15)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h/%b, want %h/%b",
                 k, beat_q[k], last_q[k], exp_d, (k == 15));
      end
    end
    n_cmp++;
    if (pop_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_pops: got %0d, want 4", pop_cyc.size());
    end
  endtask

  task automatic test_reset_midburst();
    int budget;
    @(negedge clk);
    out_ready = 1'b1;
    clear_capture();
    push(64'h0101_0202_0303_0404);
    push(64'h0505_0606_0707_0808);
    push(64'h0909_0A0A_0B0B_0C0C);
    push(64'h0D0D_0E0E_0F0F_1010);
    budget = 0;
    while (beat_q.size() < 5 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h0606) begin
      n_fail++;
      $display("FAIL mid_beat6: got vld=%b data=%h, want 1/0606", out_valid, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({fifo_rd_en, out_valid, out_last, busy} !== 4'b0000 || out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rd/vld/last/busy=%b data=%h, want 0000/0000",
               {fifo_rd_en, out_valid, out_last, busy}, out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (fifo_numel !== 5'd2 || pop_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL mid_numel: got numel=%0d pops=%0d, want 2/2",
               fifo_numel, pop_cyc.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: got busy=%b, want 0", busy);
    end
    rst = 1'b0;
    do_flush();
  endtask

`ifdef FIFO_DRAIN_HDR_EN
  task automatic test_header();
    logic [63:0] words [3];
    logic [63:0] w;
    logic [15:0] exp_d;
    int          budget;
    words = '{64'h1000_2000_3000_4000, 64'h5000_6000_7000_8000,
              64'h9000_A000_B000_C000};
    @(negedge clk);
    out_ready = 1'b1;
    clear_capture();
    for (int i = 0; i < 3; i++) push(words[i]);
    budget = 0;
    while (beat_q.size() < 13 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (beat_q.size() !== 13) begin
      n_fail++;
      $display("FAIL hdr_beats: got %0d, want 13", beat_q.size());
    end
    if (beat_q.size() > 0) begin
      n_cmp++;
      if (beat_q[0] !== 16'hA503 || last_q[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hdr_word: got %h/%b, want a503/0", beat_q[0], last_q[0]);
      end
    end
    for (int k = 1; k < 13 && k < beat_q.size(); k++) begin
      w = words[(k - 1) / 4];
      exp_d = w[63 - 16 * ((k - 1) % 4) -: 16];
      n_cmp++;
      if (beat_q[k] !== exp_d || last_q[k] !== (k == 12)) begin
        n_fail++;
        $display("FAIL hdr_beat%0d: got %h/%b, want %h/%b",
                 k, beat_q[k], last_q[k], exp_d, (k == 12));
      end
    end
    n_cmp++;
    if (pop_cyc.size() !== 3) begin
      n_fail++;
      $display("FAIL hdr_pops: got %0d, want 3", pop_cyc.size());
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    test_reset();
`ifdef FIFO_DRAIN_HDR_EN
    test_header();
`else
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_reset_midburst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
